// File: rtl/core_dbg_pkg.sv
// rtl/core_dbg_pkg.sv - shared types and constants for the core run monitor
package core_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_DONE
   } run_state_t;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_DEPTH       = 16;
   localparam int DEF_RST_CYCLES  = 2;
   localparam int DEF_STALL_LIMIT = 8;
   localparam int DEF_TIMEOUT     = 4096;

   // One trace record is the PC followed by every watched channel.
   function automatic int rec_width(input int width, input int channels);
      return (channels + 1) * width;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through trace FIFO with sticky overflow
module trace_fifo #(
   parameter int DW    = 160,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          clear,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] head,
   output logic          valid,
   output logic          full,
   output logic          overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop_ok;
   logic          push_ok;

   assign valid   = (count != '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign pop_ok  = pop && valid;
   // A full FIFO still takes a push when the same cycle frees a slot.
   assign push_ok = push && (!full || pop_ok);
   assign head    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
         if (push && !push_ok) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/core_run_monitor.sv
// rtl/core_run_monitor.sv - core reset sequencer, cycle counter, halt/timeout detector and PC trace
module core_run_monitor
   import core_dbg_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int CHANNELS    = DEF_CHANNELS,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int RST_CYCLES  = DEF_RST_CYCLES,
   parameter int STALL_LIMIT = DEF_STALL_LIMIT,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                                Clk,
   input  logic                                Rst_n,
   input  logic                                Start,
   output logic                                CoreRst,
   input  logic [WIDTH-1:0]                    PCValue,
   input  logic [CHANNELS*WIDTH-1:0]           Watch,
   input  logic                                TraceRd,
   output logic [rec_width(WIDTH,CHANNELS)-1:0] TraceData,
   output logic                                TraceValid,
   output logic                                TraceOverflow,
   output logic                                Done,
   output logic                                TimedOut,
   output logic [31:0]                         CycleCount
);

   run_state_t       state;
   run_state_t       state_nx;
   logic [31:0]      rst_cnt;
   logic [31:0]      stall_cnt;
   logic [31:0]      stall_nx;
   logic [WIDTH-1:0] prev_pc;
   logic             first_run;
   logic             pc_same;
   logic             halt;
   logic             tmo;
   logic             start_ok;
   logic             push;

   // The first RUN cycle has no meaningful prev_pc, so it never counts as a stall.
   assign pc_same  = (PCValue == prev_pc) && !first_run;
   assign stall_nx = pc_same ? stall_cnt + 32'd1 : 32'd0;
   assign halt     = pc_same && (stall_nx == 32'(STALL_LIMIT - 1));
   assign tmo      = ((CycleCount + 32'd1) == 32'(TIMEOUT));
   assign start_ok = Start && ((state == ST_IDLE) || (state == ST_DONE));
   assign push     = (state == ST_RUN) && (first_run || (PCValue != prev_pc));

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (Start) state_nx = ST_RESET;
         ST_RESET: if (rst_cnt == 32'd0) state_nx = ST_RUN;
         ST_RUN:   if (halt || tmo) state_nx = ST_DONE;
         ST_DONE:  if (Start) state_nx = ST_RESET;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= ST_IDLE;
         CoreRst    <= 1'b1;
         CycleCount <= 32'd0;
         Done       <= 1'b0;
         TimedOut   <= 1'b0;
         stall_cnt  <= 32'd0;
         rst_cnt    <= 32'd0;
         prev_pc    <= '0;
         first_run  <= 1'b0;
      end else begin
         state   <= state_nx;
         CoreRst <= (state_nx != ST_RUN);
         if (start_ok) begin
            CycleCount <= 32'd0;
            Done       <= 1'b0;
            TimedOut   <= 1'b0;
            stall_cnt  <= 32'd0;
            rst_cnt    <= 32'(RST_CYCLES - 1);
            first_run  <= 1'b1;
         end else if (state == ST_RESET) begin
            if (rst_cnt != 32'd0) begin
               rst_cnt <= rst_cnt - 32'd1;
            end
         end else if (state == ST_RUN) begin
            CycleCount <= CycleCount + 32'd1;
            prev_pc    <= PCValue;
            stall_cnt  <= stall_nx;
            first_run  <= 1'b0;
            if (halt) Done <= 1'b1;
            if (tmo)  TimedOut <= 1'b1;
         end
      end
   end

   trace_fifo #(
      .DW    (rec_width(WIDTH, CHANNELS)),
      .DEPTH (DEPTH)
   ) u_trace_fifo (
      .clk      (Clk),
      .rst_n    (Rst_n),
      .push     (push),
      .pop      (TraceRd),
      .clear    (start_ok),
      .din      ({PCValue, Watch}),
      .head     (TraceData),
      .valid    (TraceValid),
      .full     (),
      .overflow (TraceOverflow)
   );

endmodule

// File: tb/tb_core_run_monitor.sv
// tb/tb_core_run_monitor.sv - directed self-checking bench for core_run_monitor
module tb_core_run_monitor;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         core_rst;
   logic [31:0]  pc;
   logic [127:0] watch;
   logic         rd;
   logic [159:0] data;
   logic         valid;
   logic         ovf;
   logic         done;
   logic         to;
   logic [31:0]  cyc;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   core_run_monitor #(
      .WIDTH(32), .CHANNELS(4), .DEPTH(4),
      .RST_CYCLES(2), .STALL_LIMIT(8), .TIMEOUT(20)
   ) dut (
      .Clk(clk), .Rst_n(rst_n), .Start(start), .CoreRst(core_rst),
      .PCValue(pc), .Watch(watch), .TraceRd(rd), .TraceData(data),
      .TraceValid(valid), .TraceOverflow(ovf), .Done(done),
      .TimedOut(to), .CycleCount(cyc)
   );

   function automatic logic [127:0] wv(input logic [31:0] p);
      return {p + 32'h3000_0000, p + 32'h2000_0000, p + 32'h1000_0000, p ^ 32'hFFFF_0000};
   endfunction

   function automatic logic [159:0] rec(input logic [31:0] p);
      return {p, wv(p)};
   endfunction

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after RUN is entered.
   task automatic do_start(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " rst_hold1"}, core_rst, 1);
      check({tag, " clr_valid"}, valid, 0);
      check({tag, " clr_done"}, done, 0);
      check({tag, " clr_to"}, to, 0);
      check({tag, " clr_cyc"}, cyc, 0);
      @(negedge clk);
      check({tag, " rst_hold2"}, core_rst, 1);
      @(negedge clk);
      check({tag, " rst_release"}, core_rst, 0);
   endtask

   task automatic drive(input logic [31:0] p, input logic r);
      pc    = p;
      watch = wv(p);
      rd    = r;
      @(negedge clk);
      rd    = 1'b0;
   endtask

   task automatic pop_expect(input string tag, input logic [31:0] p);
      check({tag, " valid"}, valid, 1);
      check(tag, data, rec(p));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      pc    = 32'd0;
      watch = wv(32'd0);
      rd    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst core_rst", core_rst, 1);
      check("rst valid", valid, 0);
      check("rst data", data, 0);
      check("rst ovf", ovf, 0);
      check("rst done", done, 0);
      check("rst to", to, 0);
      check("rst cyc", cyc, 0);

      // Halt: PC 0, 4, 8 then holds at 8.
      do_start("run1");
      drive(32'd0, 1'b0);
      check("run1 cyc1", cyc, 1);
      check("run1 first_valid", valid, 1);
      check("run1 first_rec", data, rec(32'd0));
      drive(32'd4, 1'b0);
      check("run1 cyc2", cyc, 2);
      drive(32'd8, 1'b0);
      check("run1 cyc3", cyc, 3);
      for (int k = 4; k <= 9; k++) drive(32'd8, 1'b0);
      check("run1 halt_early", done, 0);
      drive(32'd8, 1'b0);
      check("run1 done", done, 1);
      check("run1 to", to, 0);
      check("run1 core_rst", core_rst, 1);
      check("run1 cyc_stop", cyc, 10);
      drive(32'd8, 1'b0);
      check("run1 cyc_hold", cyc, 10);
      pop_expect("run1 rec0", 32'd0);
      pop_expect("run1 rec1", 32'd4);

      // Overflow and timeout, started from DONE with one record left over.
      do_start("run2");
      for (int k = 1; k <= 20; k++) begin
         drive(32'd100 + 32'(4 * k), 1'b0);
         if (k == 4)  check("run2 ovf_before", ovf, 0);
         if (k == 5)  check("run2 ovf_set", ovf, 1);
         if (k == 19) check("run2 to_early", to, 0);
      end
      check("run2 to", to, 1);
      check("run2 done", done, 0);
      check("run2 cyc", cyc, 20);
      check("run2 core_rst", core_rst, 1);
      pop_expect("run2 rec0", 32'd104);
      pop_expect("run2 rec1", 32'd108);
      pop_expect("run2 rec2", 32'd112);
      pop_expect("run2 rec3", 32'd116);
      check("run2 empty", valid, 0);
      check("run2 empty_data", data, 0);

      // Push and pop together while full.
      do_start("run3");
      for (int k = 1; k <= 4; k++) drive(32'd200 + 32'(k), 1'b0);
      drive(32'd205, 1'b1);
      check("run3 valid", valid, 1);
      check("run3 ovf", ovf, 0);
      check("run3 head", data, rec(32'd202));
      for (int k = 6; k <= 12; k++) drive(32'd205, 1'b0);
      check("run3 done", done, 1);
      check("run3 ovf_end", ovf, 0);
      check("run3 cyc", cyc, 12);
      pop_expect("run3 rec0", 32'd202);
      pop_expect("run3 rec1", 32'd203);
      pop_expect("run3 rec2", 32'd204);
      pop_expect("run3 rec3", 32'd205);
      check("run3 empty", valid, 0);

      // Start ignored in RUN, then asynchronous reset mid-run.
      do_start("run4");
      drive(32'd300, 1'b0);
      pc    = 32'd304;
      watch = wv(32'd304);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("run4 start_ignored_cyc", cyc, 2);
      check("run4 start_ignored_rst", core_rst, 0);
      rst_n = 1'b0;
      #1;
      check("run4 async_core_rst", core_rst, 1);
      check("run4 async_cyc", cyc, 0);
      check("run4 async_valid", valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("run4 idle_core_rst", core_rst, 1);
      do_start("run5");
      drive(32'd500, 1'b0);
      drive(32'd504, 1'b0);
      check("run5 cyc", cyc, 2);
      check("run5 head", data, rec(32'd500));
      check("run5 ovf", ovf, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/core_run_monitor.md
# core_run_monitor

Synthesizable run controller and trace monitor that sits beside the pipelined processor top. It sequences the core's reset and counts execution cycles. It captures a trace record of the PC plus CHANNELS watched register values every time the PC changes. It flags completion when the PC stalls (halt loop) or when a cycle budget expires, so runs are checked in hardware rather than by waveform inspection.

## Interface
- WIDTH, 32: data width of the PC and of each watch channel
- CHANNELS, 4: number of watched values (e.g. v0, v1, MIN, test regs)
- DEPTH, 16: trace FIFO entries; power of two, ≥2
- RST_CYCLES, 2: cycles CoreRst is held high after Start
- STALL_LIMIT, 8: consecutive unchanged-PC cycles that mean halt; ≥2
- TIMEOUT, 4096: cycle budget in RUN; must fit in 32 bits

- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Start  in  1  single-cycle pulse; begins a run from IDLE or DONE
- CoreRst  out  1  active-high reset to the core (drives PC_Rst)
- PCValue  in  WIDTH  core's current PC
- Watch  in  CHANNELS*WIDTH  watched values; channel i at bits [i*WIDTH +: WIDTH]
- TraceRd  in  1  pop the FIFO head
- TraceData  out  (CHANNELS+1)*WIDTH  FIFO head: {PC, Watch}; PC in the MSBs
- TraceValid  out  1  FIFO not empty
- TraceOverflow  out  1  sticky; a push was dropped
- Done  out  1  sticky; halt detected
- TimedOut  out  1  sticky; budget expired
- CycleCount  out  32  RUN cycles elapsed

## Operation
- Reset state: IDLE. CoreRst=1, CycleCount=0, Done=0, TimedOut=0, TraceOverflow=0, TraceValid=0, FIFO empty, stall count 0, prev_pc 0.
- FSM IDLE→RESET→RUN→DONE. In DONE, a Start pulse returns to RESET.
- IDLE: CoreRst=1. Start moves to RESET.
- Start in IDLE/DONE: clear the FIFO, all flags, CycleCount and stall count; load the reset counter.
- Start is ignored in RESET and RUN.
- RESET: CoreRst=1 for exactly RST_CYCLES cycles, then RUN.
- RUN: CoreRst=0. CycleCount increments every cycle.
- Trace push in RUN: always on the first RUN cycle; after that, whenever PCValue ≠ prev_pc. prev_pc loads PCValue every RUN cycle.
- Stall counter: +1 when PCValue == prev_pc (first RUN cycle excluded); otherwise cleared.
- Halt: the stall counter would reach STALL_LIMIT−1 and PC is still unchanged → DONE, Done=1.
- Timeout: CycleCount would reach TIMEOUT → DONE, TimedOut=1.
- Halt and timeout in the same cycle: set both flags.
- DONE: CoreRst=1 (core frozen). Counters and flags hold. The FIFO stays readable.
- FIFO behaviour:
  - First-word-fall-through: TraceData shows the head whenever TraceValid=1; TraceData=0 when empty.
  - TraceRd pops in any state. TraceRd while empty is ignored.
  - Push while full and no pop: the record is dropped and TraceOverflow is set.
  - Push and pop in the same cycle while full: both are accepted and the count is unchanged.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Rst_n asserted mid-run: immediate return to the reset state above. CoreRst rises asynchronously.

## Timing
- All outputs are registered except TraceData and TraceValid, which are derived from registered FIFO state.
- Start at edge n: CoreRst stays high through edge n+RST_CYCLES. RUN is entered at edge n+RST_CYCLES and CoreRst falls with it.
- The first trace record is written at the first RUN edge. It is readable at the following cycle.
- Push-to-TraceValid latency: 1 cycle.
- Pop: TraceData updates at the next edge.
- Done/TimedOut and the DONE state assert at the edge after the deciding comparison. CycleCount stops at that same edge.

## Structure
- Shared package core_dbg_pkg holds:
  - the state enum (IDLE, RESET, RUN, DONE)
  - the record width function (CHANNELS+1)*WIDTH
  - default parameter constants
- One sub-module, trace_fifo:
  - parametrised by data width and DEPTH
  - provides push, pop, clear, head, valid, full and overflow
- The FSM, counters and comparator stay in core_run_monitor.

## Test plan
- Rst_n low then high, no Start → CoreRst=1, TraceValid=0, all flags 0. Start → CoreRst high exactly 2 cycles, then 0; CycleCount counts 1, 2, 3, …
- PCValue steps 0, 4, 8, then holds at 8 for 8 cycles → 3 records (PC 0, 4, 8 with their Watch values); Done=1; TimedOut=0; CoreRst=1.
- DEPTH=4, PC incrementing every cycle, no reads → 4 records retained (the first 4 PCs); TraceOverflow=1 on the 5th push.
- TIMEOUT=20, PC incrementing → TimedOut=1 with CycleCount=20; Done=0.
- FIFO full with TraceRd and a push in the same cycle → TraceValid stays 1, no overflow, the old head is replaced by the next entry.
- Rst_n pulsed low mid-RUN, then Start after release → all state cleared, then a clean second run. Also: Start in DONE clears the old trace and flags.
